// File: rtl/dii_package.sv
// rtl/dii_package.sv - debug interconnect flit type
package dii_package;

  // One 16-bit flit of a debug interconnect packet
  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;

endpackage

// File: rtl/osd_event_pkg.sv
// rtl/osd_event_pkg.sv - event protocol constants shared by packetizer and depacketizer
package osd_event_pkg;

  localparam logic [1:0] TYPE_EVENT        = 2'b10;
  localparam logic [3:0] TYPE_SUB_EV_LAST  = 4'h0;
  localparam logic [3:0] TYPE_SUB_EV_CONT  = 4'h1;
  localparam logic [3:0] TYPE_SUB_OVERFLOW = 4'h5;

  typedef enum logic [2:0] {
    ST_DEST,
    ST_SRC,
    ST_FLAGS,
    ST_PAYLOAD,
    ST_OUT,
    ST_DROP
  } state_t;

  function automatic logic type_sub_legal(input logic [3:0] sub);
    return (sub == TYPE_SUB_EV_LAST) || (sub == TYPE_SUB_EV_CONT) ||
           (sub == TYPE_SUB_OVERFLOW);
  endfunction

endpackage

// File: rtl/osd_event_depacketization_fixedwidth_if.sv
// rtl/osd_event_depacketization_fixedwidth_if.sv - flit input and event record bundle
interface osd_event_depacketization_fixedwidth_if #(
  parameter int DATA_WIDTH = 112
);
  import dii_package::*;

  dii_flit                 debug_in;
  logic                    debug_in_ready;
  logic [DATA_WIDTH-1:0]   event_data;
  logic [15:0]             event_src;
  logic                    event_overflow;
  logic [15:0]             event_lost;
  logic                    event_valid;
  logic                    event_ready;
  logic                    err;

  // Depacketizer side
  modport slave (
    input  debug_in, event_ready,
    output debug_in_ready, event_data, event_src, event_overflow,
           event_lost, event_valid, err
  );

  // Interconnect / consumer side
  modport master (
    output debug_in, event_ready,
    input  debug_in_ready, event_data, event_src, event_overflow,
           event_lost, event_valid, err
  );

endinterface

// File: rtl/osd_event_depacketization_fixedwidth.sv
// rtl/osd_event_depacketization_fixedwidth.sv - rebuild fixed-width events from DII event packets
module osd_event_depacketization_fixedwidth
  import dii_package::*;
  import osd_event_pkg::*;
#(
  parameter int DATA_WIDTH  = 112,
  parameter int MAX_PKT_LEN = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] id,
  osd_event_depacketization_fixedwidth_if.slave bus
);

  localparam int NW = (DATA_WIDTH + 15) / 16;
  localparam int P  = MAX_PKT_LEN - 3;
  localparam int CW = $clog2(NW + 1);

  state_t             state, state_n;
  logic [CW-1:0]      wcnt, wcnt_n;
  logic [CW-1:0]      pcnt, pcnt_n;
  logic [NW*16-1:0]   acc, acc_n;
  logic [15:0]        src_q, src_n;
  logic [3:0]         sub_q, sub_n;
  logic [15:0]        lost_q, lost_n;
  logic               ovf_q, ovf_n;
  logic               err_q, err_n;

  dii_flit            flit;
  logic               ready;
  logic               fire;
  logic [3:0]         flag_sub;

  assign flit     = bus.debug_in;
  assign ready    = !rst && (state != ST_OUT);
  assign fire     = flit.valid && ready;
  assign flag_sub = flit.data[13:10];

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_DEST;
    else     state <= state_n;
  end

  // Next state and datapath updates; any protocol error abandons the partial event
  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    pcnt_n  = pcnt;
    acc_n   = acc;
    src_n   = src_q;
    sub_n   = sub_q;
    lost_n  = lost_q;
    ovf_n   = ovf_q;
    err_n   = 1'b0;
    unique case (state)
      ST_DEST: if (fire) begin
        if (flit.last) begin
          err_n  = 1'b1;
          wcnt_n = '0;
        end else if (flit.data != id) begin
          err_n   = 1'b1;
          wcnt_n  = '0;
          state_n = ST_DROP;
        end else begin
          state_n = ST_SRC;
        end
      end
      ST_SRC: if (fire) begin
        if (flit.last) begin
          err_n   = 1'b1;
          wcnt_n  = '0;
          state_n = ST_DEST;
        end else if ((wcnt != '0) && (flit.data != src_q)) begin
          err_n   = 1'b1;
          wcnt_n  = '0;
          state_n = ST_DROP;
        end else begin
          src_n   = flit.data;
          state_n = ST_FLAGS;
        end
      end
      ST_FLAGS: if (fire) begin
        pcnt_n = '0;
        sub_n  = flag_sub;
        if (flit.last) begin
          err_n   = 1'b1;
          wcnt_n  = '0;
          state_n = ST_DEST;
        end else if ((flit.data[15:14] != TYPE_EVENT) || !type_sub_legal(flag_sub)) begin
          err_n   = 1'b1;
          wcnt_n  = '0;
          state_n = ST_DROP;
        end else begin
          if (flag_sub == TYPE_SUB_OVERFLOW) wcnt_n = '0;
          state_n = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: if (fire) begin
        if (sub_q == TYPE_SUB_OVERFLOW) begin
          if (pcnt != '0) begin
            err_n   = 1'b1;
            state_n = flit.last ? ST_DEST : ST_DROP;
          end else begin
            lost_n = flit.data;
            pcnt_n = CW'(1);
            if (flit.last) begin
              ovf_n   = 1'b1;
              state_n = ST_OUT;
            end
          end
        end else if ((32'(wcnt) == NW) || (32'(pcnt) == P)) begin
          err_n   = 1'b1;
          wcnt_n  = '0;
          state_n = flit.last ? ST_DEST : ST_DROP;
        end else begin
          acc_n[{wcnt, 4'b0000} +: 16] = flit.data;
          wcnt_n = wcnt + CW'(1);
          pcnt_n = pcnt + CW'(1);
          if (flit.last) begin
            if ((sub_q == TYPE_SUB_EV_LAST) && (32'(wcnt) + 1 == NW)) begin
              wcnt_n  = '0;
              ovf_n   = 1'b0;
              state_n = ST_OUT;
            end else if ((sub_q == TYPE_SUB_EV_CONT) && (32'(pcnt) + 1 == P) &&
                         (32'(wcnt) + 1 < NW)) begin
              state_n = ST_DEST;
            end else begin
              err_n   = 1'b1;
              wcnt_n  = '0;
              state_n = ST_DEST;
            end
          end
        end
      end
      ST_OUT: if (bus.event_ready) begin
        ovf_n   = 1'b0;
        state_n = ST_DEST;
      end
      ST_DROP: if (fire && flit.last) begin
        state_n = ST_DEST;
      end
      default: state_n = ST_DEST;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt   <= '0;
      pcnt   <= '0;
      acc    <= '0;
      src_q  <= '0;
      sub_q  <= '0;
      lost_q <= '0;
      ovf_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      wcnt   <= wcnt_n;
      pcnt   <= pcnt_n;
      acc    <= acc_n;
      src_q  <= src_n;
      sub_q  <= sub_n;
      lost_q <= lost_n;
      ovf_q  <= ovf_n;
      err_q  <= err_n;
    end
  end

  assign bus.debug_in_ready = ready;
  assign bus.event_valid    = (state == ST_OUT);
  assign bus.event_data     = ((state == ST_OUT) && !ovf_q) ? acc[DATA_WIDTH-1:0] : '0;
  assign bus.event_src      = (state == ST_OUT) ? src_q : 16'h0;
  assign bus.event_overflow = (state == ST_OUT) && ovf_q;
  assign bus.event_lost     = ((state == ST_OUT) && ovf_q) ? lost_q : 16'h0;
  assign bus.err            = err_q;

endmodule
